eig_serializer: RTL and testbench

Downstream collector for the three 2x2 eigenvalue solvers. It captures the converged 4x4 matrix and the three solver results, then decides per diagonal position whether the eigenvalue is a real diagonal entry or half of a complex-conjugate pair. It emits exactly four eigenvalues (real, imaginary) in index order over a valid/ready stream, and is the last stage before the result interface.

---
 rtl/eig_serializer.sv | 232 +++++++++++++++++++++++
 tb/tb_eig_serializer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/eig_serializer.sv
// Collects the converged 4x4 matrix and three 2x2 solver results, then streams four
// eigenvalues in index order. Define EIG_SER_ZERO_TOL_EN to use a magnitude tolerance on subdiagonals.
module eig_serializer #(
    parameter int unsigned SETTLE   = 4,
    parameter logic [15:0] ZERO_TOL = 16'd2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [255:0] A_new,
    input  logic [15:0]  eig_reel_1,
    input  logic [15:0]  eig_reel_2,
    input  logic [15:0]  eig_reel_3,
    input  logic [15:0]  eig_comp_1,
    input  logic [15:0]  eig_comp_2,
    input  logic [15:0]  eig_comp_3,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [15:0]  out_reel,
    output logic [15:0]  out_comp,
    output logic [1:0]   out_idx,
    output logic         out_last,
    output logic         busy,
    output logic         done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_EMIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [7:0] SETTLE_M1 = 8'(SETTLE - 1);

`ifdef EIG_SER_ZERO_TOL_EN
    // 17-bit magnitude so that 0x8000 maps to 32768 rather than wrapping
    function automatic logic [16:0] abs17(input logic [15:0] v);
        if (v[15]) begin
            return 17'h1_0000 - {1'b0, v};
        end else begin
            return {1'b0, v};
        end
    endfunction

    function automatic logic nonzero(input logic [15:0] v);
        return abs17(v) > {1'b0, ZERO_TOL};
    endfunction
`else
    function automatic logic nonzero(input logic [15:0] v);
        return v != 16'h0000;
    endfunction
`endif

    state_t      state_r, state_s;
    logic [7:0]  cnt_r, cnt_s;
    logic [15:0] d_r  [0:3];
    logic [15:0] re_r [1:3];
    logic [15:0] im_r [1:3];
    logic [3:1]  nz_r, nz_s;
    logic        pair_r;
    logic        latch_d_s, latch_sol_s, load_s, drop_s;

    logic        out_valid_r, out_last_r, busy_r, done_r;
    logic [15:0] out_reel_r, out_comp_r;
    logic [1:0]  out_idx_r;

    logic [1:0]  pos_s, nxt_pos_s;
    logic        prev_pair_s, item_pair_s;
    logic [15:0] src_re_s [1:3];
    logic [15:0] src_im_s [1:3];
    logic [15:0] item_reel_s, item_comp_s;

    // Only the diagonal and first subdiagonal of A_new matter; the rest is folded away here
    logic unused_s;
    assign unused_s = ^{A_new, ZERO_TOL};

    assign nz_s[1] = nonzero(A_new[79:64]);
    assign nz_s[2] = nonzero(A_new[159:144]);
    assign nz_s[3] = nonzero(A_new[239:224]);

    assign out_valid = out_valid_r;
    assign out_reel  = out_reel_r;
    assign out_comp  = out_comp_r;
    assign out_idx   = out_idx_r;
    assign out_last  = out_last_r;
    assign busy      = busy_r;
    assign done      = done_r;

    // Next item to present; the first item comes straight from the solver inputs on the latch edge
    always_comb begin
        pos_s       = out_idx_r + 2'd1;
        prev_pair_s = pair_r;
        src_re_s[1] = re_r[1];
        src_re_s[2] = re_r[2];
        src_re_s[3] = re_r[3];
        src_im_s[1] = im_r[1];
        src_im_s[2] = im_r[2];
        src_im_s[3] = im_r[3];
        if (state_r == ST_WAIT) begin
            pos_s       = 2'd0;
            prev_pair_s = 1'b0;
            src_re_s[1] = eig_reel_1;
            src_re_s[2] = eig_reel_2;
            src_re_s[3] = eig_reel_3;
            src_im_s[1] = eig_comp_1;
            src_im_s[2] = eig_comp_2;
            src_im_s[3] = eig_comp_3;
        end else begin
            pos_s       = out_idx_r + 2'd1;
        end
        nxt_pos_s   = pos_s + 2'd1;
        item_reel_s = d_r[pos_s];
        item_comp_s = 16'h0000;
        item_pair_s = 1'b0;
        if (prev_pair_s) begin
            // second half of a conjugate pair: the solver index equals this position
            item_reel_s = src_re_s[pos_s];
            item_comp_s = 16'h0000 - src_im_s[pos_s];
        end else if ((pos_s != 2'd3) && nz_r[nxt_pos_s]) begin
            item_reel_s = src_re_s[nxt_pos_s];
            item_comp_s = src_im_s[nxt_pos_s];
            item_pair_s = 1'b1;
        end else begin
            item_reel_s = d_r[pos_s];
            item_comp_s = 16'h0000;
        end
    end

    // Sequencing: capture, settle, stream, single-cycle done
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        latch_d_s   = 1'b0;
        latch_sol_s = 1'b0;
        load_s      = 1'b0;
        drop_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s   = ST_WAIT;
                    cnt_s     = SETTLE_M1;
                    latch_d_s = 1'b1;
                end else begin
                    state_s   = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r == 8'd0) begin
                    state_s     = ST_EMIT;
                    latch_sol_s = 1'b1;
                    load_s      = 1'b1;
                end else begin
                    cnt_s = cnt_r - 8'd1;
                end
            end
            ST_EMIT: begin
                if (out_valid_r && out_ready) begin
                    if (out_last_r) begin
                        state_s = ST_DONE;
                        drop_s  = 1'b1;
                    end else begin
                        load_s  = 1'b1;
                    end
                end else begin
                    state_s = ST_EMIT;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, latched operands and registered stream outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 8'd0;
            nz_r        <= 3'b000;
            pair_r      <= 1'b0;
            out_valid_r <= 1'b0;
            out_reel_r  <= 16'h0000;
            out_comp_r  <= 16'h0000;
            out_idx_r   <= 2'd0;
            out_last_r  <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                d_r[i] <= 16'h0000;
            end
            for (int k = 1; k < 4; k++) begin
                re_r[k] <= 16'h0000;
                im_r[k] <= 16'h0000;
            end
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            busy_r  <= (state_s != ST_IDLE);
            done_r  <= drop_s;
            if (latch_d_s) begin
                d_r[0] <= A_new[15:0];
                d_r[1] <= A_new[95:80];
                d_r[2] <= A_new[175:160];
                d_r[3] <= A_new[255:240];
                nz_r   <= nz_s;
            end
            if (latch_sol_s) begin
                re_r[1] <= eig_reel_1;
                re_r[2] <= eig_reel_2;
                re_r[3] <= eig_reel_3;
                im_r[1] <= eig_comp_1;
                im_r[2] <= eig_comp_2;
                im_r[3] <= eig_comp_3;
            end
            if (load_s) begin
                out_valid_r <= 1'b1;
                out_reel_r  <= item_reel_s;
                out_comp_r  <= item_comp_s;
                out_idx_r   <= pos_s;
                out_last_r  <= (pos_s == 2'd3);
                pair_r      <= item_pair_s;
            end else if (drop_s) begin
                out_valid_r <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_eig_serializer.sv
// Directed bench for eig_serializer: scoreboard of expected eigenvalues checked on every transfer,
// plus cycle-accurate checks of valid/done/busy timing, stall stability and mid-stream reset.
module tb_eig_serializer;

    logic         clk = 1'b0;
    logic         rst, start, out_ready;
    logic [255:0] A_new;
    logic [15:0]  eig_reel_1, eig_reel_2, eig_reel_3;
    logic [15:0]  eig_comp_1, eig_comp_2, eig_comp_3;
    logic         out_valid, out_last, busy, done;
    logic [15:0]  out_reel, out_comp;
    logic [1:0]   out_idx;

    typedef struct packed {
        logic [15:0] reel;
        logic [15:0] comp;
        logic [1:0]  idx;
        logic        last;
    } item_t;

    item_t sb[$];
    int    checks = 0;
    int    failures = 0;

    always #5 clk = ~clk;

    eig_serializer #(.SETTLE(4), .ZERO_TOL(16'd2)) dut (
        .clk(clk), .rst(rst), .start(start), .A_new(A_new),
        .eig_reel_1(eig_reel_1), .eig_reel_2(eig_reel_2), .eig_reel_3(eig_reel_3),
        .eig_comp_1(eig_comp_1), .eig_comp_2(eig_comp_2), .eig_comp_3(eig_comp_3),
        .out_valid(out_valid), .out_ready(out_ready), .out_reel(out_reel),
        .out_comp(out_comp), .out_idx(out_idx), .out_last(out_last),
        .busy(busy), .done(done)
    );

    task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] re, input logic [15:0] im, input logic [1:0] idx);
        sb.push_back({re, im, idx, (idx == 2'd3)});
    endtask

    task automatic set_mat(input logic [15:0] d0, input logic [15:0] d1, input logic [15:0] d2,
                           input logic [15:0] d3, input logic [15:0] s1, input logic [15:0] s2,
                           input logic [15:0] s3);
        for (int k = 0; k < 16; k++) A_new[16*k +: 16] = 16'h5A00 + 16'(k);
        A_new[15:0]    = d0;
        A_new[95:80]   = d1;
        A_new[175:160] = d2;
        A_new[255:240] = d3;
        A_new[79:64]   = s1;
        A_new[159:144] = s2;
        A_new[239:224] = s3;
    endtask

    task automatic set_sol(input logic [15:0] r1, input logic [15:0] c1, input logic [15:0] r2,
                           input logic [15:0] c2, input logic [15:0] r3, input logic [15:0] c3);
        eig_reel_1 = r1; eig_comp_1 = c1;
        eig_reel_2 = r2; eig_comp_2 = c2;
        eig_reel_3 = r3; eig_comp_3 = c3;
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_valid"}, out_valid, 1'b0);
        check({tag, "_reel"}, out_reel, 16'h0000);
        check({tag, "_comp"}, out_comp, 16'h0000);
        check({tag, "_idx"}, out_idx, 2'd0);
        check({tag, "_last"}, out_last, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
    endtask

    // Pulse start, count cycles until done, then confirm every expected item was consumed
    task automatic run_expect(input string tag, input int exp_cycles);
        int n;
        start = 1'b1;
        n = 0;
        do begin
            tick();
            start = 1'b0;
            n++;
        end while (!done && n < 40);
        check({tag, "_done_cycle"}, n, exp_cycles);
        tick();
        check({tag, "_sb_left"}, sb.size(), 0);
    endtask

    // Scoreboard and stall-stability monitor, sampled mid-cycle
    logic        stall_q = 1'b0;
    logic [34:0] stall_data = '0;
    item_t       exp_it;
    always @(negedge clk) begin
        if (rst) begin
            stall_q <= 1'b0;
        end else begin
            if (stall_q) begin
                check("stall_valid", out_valid, 1'b1);
                check("stall_data", {out_reel, out_comp, out_idx, out_last}, stall_data);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("xfer_unexpected", sb.size(), 1);
                end else begin
                    exp_it = sb.pop_front();
                    check("xfer", {out_reel, out_comp, out_idx, out_last}, exp_it);
                end
            end
            stall_q    <= out_valid && !out_ready;
            stall_data <= {out_reel, out_comp, out_idx, out_last};
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1; start = 1'b0; out_ready = 1'b1; A_new = '0;
        set_sol(16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
        repeat (3) tick();
        check_idle_zero("reset");
        rst = 1'b0;
        tick();

        // All real: cycle-exact valid/done/busy profile
        set_mat(16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0, 16'h0, 16'h0);
        set_sol(16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666);
        push(16'h0100, 16'h0, 2'd0); push(16'h0200, 16'h0, 2'd1);
        push(16'h0300, 16'h0, 2'd2); push(16'h0400, 16'h0, 2'd3);
        start = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            start = 1'b0;
            check($sformatf("t1_valid_c%0d", k), out_valid, (k >= 5 && k <= 8));
            check($sformatf("t1_done_c%0d", k), done, (k == 9));
            check($sformatf("t1_busy_c%0d", k), busy, (k <= 9));
        end
        check("t1_sb_left", sb.size(), 0);

        // Pair at idx 0/1, rest real; solvers 2/3 must not appear
        set_mat(16'h0111, 16'h0222, 16'h0300, 16'h0400, 16'h0010, 16'h0, 16'h0);
        set_sol(16'h0080, 16'h0040, 16'hDEAD, 16'hBEEF, 16'h1234, 16'h5678);
        push(16'h0080, 16'h0040, 2'd0); push(16'h0080, 16'hFFC0, 2'd1);
        push(16'h0300, 16'h0, 2'd2); push(16'h0400, 16'h0, 2'd3);
        run_expect("t2", 9);

        // All subdiagonals set: pairs 0/1 and 2/3, s2 never examined
        set_mat(16'h0111, 16'h0222, 16'h0333, 16'h0444, 16'h0010, 16'h0010, 16'h0010);
        set_sol(16'h0080, 16'h0040, 16'h0B00, 16'h0222, 16'h0A00, 16'h0100);
        push(16'h0080, 16'h0040, 2'd0); push(16'h0080, 16'hFFC0, 2'd1);
        push(16'h0A00, 16'h0100, 2'd2); push(16'h0A00, 16'hFF00, 2'd3);
        run_expect("t3", 9);

        // Three-cycle stall on idx1 with an ignored start inside it
        set_mat(16'h0111, 16'h0222, 16'h0305, 16'h0406, 16'h0010, 16'h0, 16'h0);
        set_sol(16'h0081, 16'h0041, 16'hDEAD, 16'hBEEF, 16'h1234, 16'h5678);
        push(16'h0081, 16'h0041, 2'd0); push(16'h0081, 16'hFFBF, 2'd1);
        push(16'h0305, 16'h0, 2'd2); push(16'h0406, 16'h0, 2'd3);
        start = 1'b1;
        tick(); start = 1'b0;
        repeat (5) tick();
        check("t4_idx1_valid", out_valid, 1'b1);
        check("t4_idx1_idx", out_idx, 2'd1);
        out_ready = 1'b0;
        tick(); start = 1'b1;
        tick(); start = 1'b0;
        check("t4_stall_busy", busy, 1'b1);
        tick(); out_ready = 1'b1;
        n = 9;
        while (!done && n < 40) begin
            tick();
            n++;
        end
        check("t4_done_cycle", n, 12);
        tick();
        tick();
        check("t4_busy_after", busy, 1'b0);
        check("t4_sb_left", sb.size(), 0);

        // Reset while idx2 is presented, then a clean full run
        set_mat(16'h1000, 16'h2000, 16'h3000, 16'h4000, 16'h0, 16'h0, 16'h0);
        push(16'h1000, 16'h0, 2'd0); push(16'h2000, 16'h0, 2'd1);
        push(16'h3000, 16'h0, 2'd2); push(16'h4000, 16'h0, 2'd3);
        start = 1'b1;
        n = 0;
        do begin
            tick();
            start = 1'b0;
            n++;
        end while (!(out_valid && out_idx == 2'd2) && n < 30);
        check("t5_reach_idx2", out_idx, 2'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle_zero("t5_rst");
        check("t5_sb_left", sb.size(), 2);
        sb.delete();
        set_mat(16'h1001, 16'h2002, 16'h3003, 16'h4004, 16'h0, 16'h0, 16'h0010);
        set_sol(16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD, 16'h0C00, 16'h0007);
        push(16'h1001, 16'h0, 2'd0); push(16'h2002, 16'h0, 2'd1);
        push(16'h0C00, 16'h0007, 2'd2); push(16'h0C00, 16'hFFF9, 2'd3);
        run_expect("t5b", 9);

        // Tolerance boundary: s1 = 1 is below ZERO_TOL only with the tolerance build
        set_mat(16'h0111, 16'h0222, 16'h0333, 16'h0444, 16'h0001, 16'h0, 16'h0);
        set_sol(16'h0080, 16'h0040, 16'hDEAD, 16'hBEEF, 16'h1234, 16'h5678);
`ifdef EIG_SER_ZERO_TOL_EN
        push(16'h0111, 16'h0, 2'd0); push(16'h0222, 16'h0, 2'd1);
`else
        push(16'h0080, 16'h0040, 2'd0); push(16'h0080, 16'hFFC0, 2'd1);
`endif
        push(16'h0333, 16'h0, 2'd2); push(16'h0444, 16'h0, 2'd3);
        run_expect("t6a", 9);

        // s1 = 0x8000 pairs in both builds; -0x8000 wraps to 0x8000
        set_mat(16'h0111, 16'h0222, 16'h0333, 16'h0444, 16'h8000, 16'h0, 16'h0);
        set_sol(16'h0090, 16'h8000, 16'hDEAD, 16'hBEEF, 16'h1234, 16'h5678);
        push(16'h0090, 16'h8000, 2'd0); push(16'h0090, 16'h8000, 2'd1);
        push(16'h0333, 16'h0, 2'd2); push(16'h0444, 16'h0, 2'd3);
        run_expect("t6b", 9);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
